// File: rtl/fifo_cdcc_pkg.sv
// fifo_cdcc_pkg
//   Definitions shared by the write-side and read-side pointer controllers
//   of the fifo_cdcc block.
//   - FIFO_PTR_BITS_CNT_DEFAULT    : default pointer / BRAM address width
//   - FIFO_ALMOST_FULL_THR_DEFAULT : default almost-full fill threshold
//   - ptr_diff()                   : modulo occupancy count, head - tail
package fifo_cdcc_pkg;

  localparam int FIFO_PTR_BITS_CNT_DEFAULT    = 9;
  localparam int FIFO_ALMOST_FULL_THR_DEFAULT = 480;

  // Pointers of any width up to 32 bits travel through ptr_diff
  // zero-extended to this word. The caller truncates the result back to its
  // own pointer width. The low N bits of a 32-bit difference equal the
  // N-bit modulo difference, so pointer wrap-around needs no special case.
  localparam int PTR_WORD_BITS = 32;
  typedef logic [PTR_WORD_BITS-1:0] ptr_word_t;

  function automatic ptr_word_t ptr_diff(input ptr_word_t head, input ptr_word_t tail);
    return head - tail;
  endfunction

endpackage

// File: rtl/fifo_level_monitor.sv
// fifo_level_monitor
//   Registered occupancy statistics for one side of the FIFO.
//   Ports:
//     clk         in   clock, all state on the rising edge
//     rst_n       in   asynchronous active-low reset
//     next_cnt    in   occupancy that will hold after this edge
//     clr_stat    in   synchronous clear of the high-water mark
//     fill_cnt    out  registered occupancy
//     almost_full out  registered, fill_cnt >= ALMOST_FULL_THR
//     hwm         out  largest fill_cnt seen since reset or clear
module fifo_level_monitor #(
  parameter int PTR_W           = 9,
  parameter int ALMOST_FULL_THR = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] next_cnt,
  input  logic             clr_stat,
  output logic [PTR_W-1:0] fill_cnt,
  output logic             almost_full,
  output logic [PTR_W-1:0] hwm
);

  localparam logic [PTR_W-1:0] THR = PTR_W'(ALMOST_FULL_THR);

  logic [PTR_W-1:0] fill_reg;
  logic             almost_full_reg;
  logic [PTR_W-1:0] hwm_reg;
  logic [PTR_W-1:0] hwm_next;

  // A clear reloads the mark with the level being registered now, so the
  // current occupancy is never lost from the statistic.
  always_comb begin
    hwm_next = hwm_reg;
    if (clr_stat || (next_cnt > hwm_reg)) begin
      hwm_next = next_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_reg        <= '0;
      almost_full_reg <= 1'b0;
      hwm_reg         <= '0;
    end else begin
      fill_reg        <= next_cnt;
      almost_full_reg <= (next_cnt >= THR);
      hwm_reg         <= hwm_next;
    end
  end

  assign fill_cnt    = fill_reg;
  assign almost_full = almost_full_reg;
  assign hwm         = hwm_reg;

endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl
//   Write-side pointer controller of fifo_cdcc. Owns the head pointer,
//   gates upstream writes into the dual-port BRAM, and reports write-domain
//   fill statistics.
//   Ports:
//     wr_clk        in   write-domain clock
//     wr_rst_n      in   asynchronous active-low reset
//     i_valid       in   upstream presents a word
//     o_ready       out  space available (combinational)
//     o_wr_en       out  BRAM write strobe
//     o_wr_addr     out  BRAM write address (current head)
//     i_rd_ptr      in   tail pointer, already synchronized into wr_clk
//     o_wr_ptr      out  committed head pointer for the read side
//     o_fill_cnt    out  registered occupancy
//     o_almost_full out  registered almost-full flag
//     o_hwm         out  high-water mark of o_fill_cnt
//     o_overflow    out  sticky: a word was offered while full
//     i_clr_stat    in   synchronous clear of o_overflow and o_hwm
module fifo_write_ctrl
  import fifo_cdcc_pkg::*;
#(
  parameter int INT_FIFO_PTR_BITS_CNT = FIFO_PTR_BITS_CNT_DEFAULT,
  parameter int INT_ALMOST_FULL_THR   = FIFO_ALMOST_FULL_THR_DEFAULT
) (
  input  logic                             wr_clk,
  input  logic                             wr_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic                             o_wr_en,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_wr_addr,
  input  logic [INT_FIFO_PTR_BITS_CNT-1:0] i_rd_ptr,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_wr_ptr,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_fill_cnt,
  output logic                             o_almost_full,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_hwm,
  output logic                             o_overflow,
  input  logic                             i_clr_stat
);

  localparam int               PTR_W    = INT_FIFO_PTR_BITS_CNT;
  // One slot stays empty so that full and empty are distinguishable.
  localparam logic [PTR_W-1:0] FULL_CNT = '1;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] cnt;
  logic [PTR_W-1:0] next_cnt;
  logic             full;
  logic             accept;
  logic             overflow_reg;
  logic             overflow_next;

  always_comb begin
    cnt  = PTR_W'(ptr_diff(ptr_word_t'(head_reg), ptr_word_t'(i_rd_ptr)));
    full = (cnt == FULL_CNT);
    // The BRAM itself is not reset, so no strobe leaves this block while
    // reset is held even if upstream keeps i_valid high.
    accept    = i_valid & ~full & wr_rst_n;
    head_next = head_reg + PTR_W'(accept);
    // Statistics follow the post-update head against the current tail, so
    // they land on the same edge that moves the head.
    next_cnt  = PTR_W'(ptr_diff(ptr_word_t'(head_next), ptr_word_t'(i_rd_ptr)));

    // Set takes priority over clear so an overflow in the clear cycle is kept.
    overflow_next = overflow_reg;
    if (i_clr_stat) begin
      overflow_next = 1'b0;
    end
    if (i_valid && full) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      overflow_reg <= overflow_next;
    end
  end

  fifo_level_monitor #(
    .PTR_W           (PTR_W),
    .ALMOST_FULL_THR (INT_ALMOST_FULL_THR)
  ) u_level_monitor (
    .clk         (wr_clk),
    .rst_n       (wr_rst_n),
    .next_cnt    (next_cnt),
    .clr_stat    (i_clr_stat),
    .fill_cnt    (o_fill_cnt),
    .almost_full (o_almost_full),
    .hwm         (o_hwm)
  );

  assign o_ready    = ~full;
  assign o_wr_en    = accept;
  assign o_wr_addr  = head_reg;
  // The read side sees a new entry one wr_clk after its BRAM write.
  assign o_wr_ptr   = head_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl
//   Scoreboard bench for fifo_write_ctrl with N=3 (capacity 7), THR=5.
//   The driver applies inputs just after each rising edge and queues the
//   outputs expected for that cycle; the monitor samples the DUT on the
//   falling edge and compares against the queue head.
module tb_fifo_write_ctrl;

  logic       wr_clk;
  logic       wr_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic       o_wr_en;
  logic [2:0] o_wr_addr;
  logic [2:0] i_rd_ptr;
  logic [2:0] o_wr_ptr;
  logic [2:0] o_fill_cnt;
  logic       o_almost_full;
  logic [2:0] o_hwm;
  logic       o_overflow;
  logic       i_clr_stat;

  fifo_write_ctrl #(
    .INT_FIFO_PTR_BITS_CNT (3),
    .INT_ALMOST_FULL_THR   (5)
  ) dut (
    .wr_clk        (wr_clk),
    .wr_rst_n      (wr_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .i_rd_ptr      (i_rd_ptr),
    .o_wr_ptr      (o_wr_ptr),
    .o_fill_cnt    (o_fill_cnt),
    .o_almost_full (o_almost_full),
    .o_hwm         (o_hwm),
    .o_overflow    (o_overflow),
    .i_clr_stat    (i_clr_stat)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    string      tag;
    logic       ready;
    logic       wr_en;
    logic [2:0] addr;
    logic [2:0] ptr;
    logic [2:0] fill;
    logic       af;
    logic [2:0] hwm;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input string field, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
    end
  endtask

  // Monitor: one expected record per driven cycle, sampled mid-cycle.
  always @(negedge wr_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "ready", {2'b0, o_ready},       {2'b0, e.ready});
      chk(e.tag, "wr_en", {2'b0, o_wr_en},       {2'b0, e.wr_en});
      chk(e.tag, "addr",  o_wr_addr,             e.addr);
      chk(e.tag, "ptr",   o_wr_ptr,              e.ptr);
      chk(e.tag, "fill",  o_fill_cnt,            e.fill);
      chk(e.tag, "af",    {2'b0, o_almost_full}, {2'b0, e.af});
      chk(e.tag, "hwm",   o_hwm,                 e.hwm);
      chk(e.tag, "ovf",   {2'b0, o_overflow},    {2'b0, e.ovf});
      $display("txn %-10s ready=%0d wr_en=%0d addr=%0d ptr=%0d fill=%0d af=%0d hwm=%0d ovf=%0d",
               e.tag, o_ready, o_wr_en, o_wr_addr, o_wr_ptr, o_fill_cnt, o_almost_full, o_hwm, o_overflow);
    end
  end

  // Drive one cycle of inputs (called just after a rising edge), queue the
  // outputs expected during that cycle, then advance past the next edge.
  task automatic step(input string tag, input logic rst_n, input logic valid,
                      input logic [2:0] rd, input logic clr,
                      input logic e_ready, input logic e_en, input logic [2:0] e_addr,
                      input logic [2:0] e_ptr, input logic [2:0] e_fill, input logic e_af,
                      input logic [2:0] e_hwm, input logic e_ovf);
    exp_t e;
    wr_rst_n   = rst_n;
    i_valid    = valid;
    i_rd_ptr   = rd;
    i_clr_stat = clr;
    e.tag   = tag;
    e.ready = e_ready;
    e.wr_en = e_en;
    e.addr  = e_addr;
    e.ptr   = e_ptr;
    e.fill  = e_fill;
    e.af    = e_af;
    e.hwm   = e_hwm;
    e.ovf   = e_ovf;
    exp_q.push_back(e);
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] hm, tm, fm, hwmm, c, nc;
    logic       afm, ovm, v, rdy, en;
    int         writes, cyc;

    wr_rst_n   = 1'b0;
    i_valid    = 1'b1;
    i_rd_ptr   = 3'd0;
    i_clr_stat = 1'b0;
    @(posedge wr_clk);
    #1;

    //   tag         rst v  rd   clr rdy en addr ptr fill af hwm ovf
    // Reset held with i_valid high: no strobe, everything zero, ready high.
    step("rst",      0, 1, 3'd0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    // Seven back-to-back writes, addresses 0..6.
    step("w0",       1, 1, 3'd0, 0, 1, 1, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    step("w1",       1, 1, 3'd0, 0, 1, 1, 3'd1, 3'd1, 3'd1, 0, 3'd1, 0);
    step("w2",       1, 1, 3'd0, 0, 1, 1, 3'd2, 3'd2, 3'd2, 0, 3'd2, 0);
    step("w3",       1, 1, 3'd0, 0, 1, 1, 3'd3, 3'd3, 3'd3, 0, 3'd3, 0);
    step("w4",       1, 1, 3'd0, 0, 1, 1, 3'd4, 3'd4, 3'd4, 0, 3'd4, 0);
    step("w5",       1, 1, 3'd0, 0, 1, 1, 3'd5, 3'd5, 3'd5, 1, 3'd5, 0);
    step("w6",       1, 1, 3'd0, 0, 1, 1, 3'd6, 3'd6, 3'd6, 1, 3'd6, 0);
    // Full: eighth word is refused and flags overflow.
    step("ovf",      1, 1, 3'd0, 0, 0, 0, 3'd7, 3'd7, 3'd7, 1, 3'd7, 0);
    // Tail steps while full: ready and write in the same cycle, head wraps.
    step("rdwr",     1, 1, 3'd1, 0, 1, 1, 3'd7, 3'd7, 3'd7, 1, 3'd7, 1);
    step("wrap",     1, 0, 3'd1, 0, 0, 0, 3'd0, 3'd0, 3'd7, 1, 3'd7, 1);
    // Drain to level 3.
    step("rd2",      1, 0, 3'd2, 0, 1, 0, 3'd0, 3'd0, 3'd7, 1, 3'd7, 1);
    step("rd3",      1, 0, 3'd3, 0, 1, 0, 3'd0, 3'd0, 3'd6, 1, 3'd7, 1);
    step("rd4",      1, 0, 3'd4, 0, 1, 0, 3'd0, 3'd0, 3'd5, 1, 3'd7, 1);
    step("rd5",      1, 0, 3'd5, 0, 1, 0, 3'd0, 3'd0, 3'd4, 0, 3'd7, 1);
    // Clear: overflow drops, hwm reloads with the current level 3.
    step("clr",      1, 0, 3'd5, 1, 1, 0, 3'd0, 3'd0, 3'd3, 0, 3'd7, 1);
    step("clr_aft",  1, 0, 3'd5, 0, 1, 0, 3'd0, 3'd0, 3'd3, 0, 3'd3, 0);
    // Refill to full, then clear in the same cycle as an overflow.
    step("f0",       1, 1, 3'd5, 0, 1, 1, 3'd0, 3'd0, 3'd3, 0, 3'd3, 0);
    step("f1",       1, 1, 3'd5, 0, 1, 1, 3'd1, 3'd1, 3'd4, 0, 3'd4, 0);
    step("f2",       1, 1, 3'd5, 0, 1, 1, 3'd2, 3'd2, 3'd5, 1, 3'd5, 0);
    step("f3",       1, 1, 3'd5, 0, 1, 1, 3'd3, 3'd3, 3'd6, 1, 3'd6, 0);
    step("ovf_clr",  1, 1, 3'd5, 1, 0, 0, 3'd4, 3'd4, 3'd7, 1, 3'd7, 0);
    step("ovf_kept", 1, 0, 3'd5, 0, 0, 0, 3'd4, 3'd4, 3'd7, 1, 3'd7, 1);
    // Head at 4, space opens; reset lands mid-cycle during a burst and the
    // outputs must already be zero before the next edge.
    step("pre_rst",  1, 0, 3'd6, 0, 1, 0, 3'd4, 3'd4, 3'd7, 1, 3'd7, 1);
    step("async",    0, 1, 3'd0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    // Writing resumes at address 0.
    step("resume0",  1, 1, 3'd0, 0, 1, 1, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    step("resume1",  1, 1, 3'd0, 0, 1, 1, 3'd1, 3'd1, 3'd1, 0, 3'd1, 0);
    step("idle",     1, 0, 3'd0, 0, 1, 0, 3'd2, 3'd2, 3'd2, 0, 3'd2, 0);

    // Wrap soak: random writes, tail trailing the committed head.
    hm = 3'd2; tm = 3'd0; fm = 3'd2; hwmm = 3'd2; afm = 1'b0; ovm = 1'b0;
    writes = 0;
    cyc    = 0;
    while (writes < 100 && cyc < 2000) begin
      if (tm != hm && $urandom_range(2) == 0) tm = tm + 3'd1;
      v   = ($urandom_range(3) != 0);
      c   = hm - tm;
      rdy = (c != 3'd7);
      en  = v & rdy;
      step($sformatf("soak%0d", cyc), 1, v, tm, 0, rdy, en, hm, hm, fm, afm, hwmm, ovm);
      hm  = hm + {2'b0, en};
      nc  = hm - tm;
      fm  = nc;
      afm = (nc >= 3'd5);
      if (nc > hwmm) hwmm = nc;
      if (v && !rdy) ovm = 1'b1;
      writes += int'(en);
      cyc++;
    end
    n_chk++;
    if (writes < 100) begin
      n_fail++;
      $display("FAIL soak_writes: got %0d writes, expected 100 within 2000 cycles", writes);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge wr_clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
